// File: rtl/axi_lite_tohost_pkg.sv
// ============================================================================
//  Module : axi_lite_tohost_pkg
//  Brief  : Widths, register map, response codes and decode helpers for the
//           AXI4-Lite tohost/status register block.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package axi_lite_tohost_pkg;

    localparam int C_AXI_ADDR_WIDTH = 32;
    localparam int C_AXI_DATA_WIDTH = 32;
    localparam int C_AXI_STRB_WIDTH = C_AXI_DATA_WIDTH / 8;
    localparam int C_AXI_PROT_WIDTH = 3;
    localparam int C_AXI_RESP_WIDTH = 2;
    localparam int C_DATA_WIDTH     = 32;

    localparam logic [C_AXI_RESP_WIDTH-1:0] C_RESP_OKAY   = 2'b00;
    localparam logic [C_AXI_RESP_WIDTH-1:0] C_RESP_SLVERR = 2'b10;
    localparam logic [C_AXI_RESP_WIDTH-1:0] C_RESP_DECERR = 2'b11;

    localparam logic [C_AXI_ADDR_WIDTH-1:0] C_WINDOW_BYTES = 32'h0000_0014;

    // Word index within the window (offset[4:2])
    typedef enum logic [2:0] {
        REG_TOHOST   = 3'd0,
        REG_STATUS   = 3'd1,
        REG_CYCLE_LO = 3'd2,
        REG_CYCLE_HI = 3'd3,
        REG_LIMIT    = 3'd4
    } reg_sel_e;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_HAVE_AW = 2'd1,
        WR_HAVE_W  = 2'd2,
        WR_RESP    = 2'd3
    } wr_state_e;

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } rd_state_e;

    // Unsigned subtraction makes addresses below the base wrap to huge offsets
    function automatic logic in_window(input logic [C_AXI_ADDR_WIDTH-1:0] addr,
                                       input logic [C_AXI_ADDR_WIDTH-1:0] base);
        logic [C_AXI_ADDR_WIDTH-1:0] off;
        off = addr - base;
        return (off < C_WINDOW_BYTES);
    endfunction

    function automatic reg_sel_e reg_of(input logic [C_AXI_ADDR_WIDTH-1:0] addr,
                                        input logic [C_AXI_ADDR_WIDTH-1:0] base);
        logic [C_AXI_ADDR_WIDTH-1:0] off;
        off = addr - base;
        return reg_sel_e'(off[4:2]);
    endfunction

    function automatic logic [C_DATA_WIDTH-1:0] merge_strb(
        input logic [C_DATA_WIDTH-1:0]     old_val,
        input logic [C_DATA_WIDTH-1:0]     new_val,
        input logic [C_AXI_STRB_WIDTH-1:0] strb);
        logic [C_DATA_WIDTH-1:0] res;
        res = old_val;
        for (int i = 0; i < C_AXI_STRB_WIDTH; i++) begin
            if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_lite_tohost.sv
// ============================================================================
//  Module : axi_lite_tohost
//  Brief  : AXI4-Lite slave exposing TOHOST/STATUS/CYCLE/LIMIT registers that
//           signal program completion, exit code and a cycle-limit timeout.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module axi_lite_tohost
    import axi_lite_tohost_pkg::*;
#(
    parameter logic [C_AXI_ADDR_WIDTH-1:0] BASE_ADDR = 32'h0001_0000
) (
    input  logic                        CLK,
    input  logic                        RST,

    input  logic                        S_AXI_AWVALID,
    output logic                        S_AXI_AWREADY,
    input  logic [C_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [C_AXI_PROT_WIDTH-1:0] S_AXI_AWPROT,

    input  logic                        S_AXI_WVALID,
    output logic                        S_AXI_WREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
    input  logic [C_AXI_STRB_WIDTH-1:0] S_AXI_WSTRB,

    output logic                        S_AXI_BVALID,
    input  logic                        S_AXI_BREADY,
    output logic [C_AXI_RESP_WIDTH-1:0] S_AXI_BRESP,

    input  logic                        S_AXI_ARVALID,
    output logic                        S_AXI_ARREADY,
    input  logic [C_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [C_AXI_PROT_WIDTH-1:0] S_AXI_ARPROT,

    output logic                        S_AXI_RVALID,
    input  logic                        S_AXI_RREADY,
    output logic [C_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic [C_AXI_RESP_WIDTH-1:0] S_AXI_RRESP,

    output logic                        done,
    output logic [C_DATA_WIDTH-1:0]     exit_code,
    output logic                        timeout
);

    wr_state_e                      r_wstate;
    wr_state_e                      w_wstate_nxt;
    rd_state_e                      r_rstate;
    rd_state_e                      w_rstate_nxt;
    logic                           r_en;
    logic                           r_wr_first;
    logic [C_AXI_ADDR_WIDTH-1:0]    r_awaddr;
    logic [C_AXI_DATA_WIDTH-1:0]    r_wdata;
    logic [C_AXI_STRB_WIDTH-1:0]    r_wstrb;
    logic [C_AXI_DATA_WIDTH-1:0]    r_rdata;
    logic [C_AXI_RESP_WIDTH-1:0]    r_rresp;

    logic [C_DATA_WIDTH-1:0]        r_tohost;
    logic [C_DATA_WIDTH-1:0]        r_limit;
    logic [63:0]                    r_cycle;
    logic [31:0]                    r_snap_hi;
    logic                           r_done;
    logic [C_DATA_WIDTH-1:0]        r_exit_code;
    logic                           r_timeout;

    logic                           w_aw_hs;
    logic                           w_w_hs;
    logic                           w_ar_hs;
    logic                           w_wr_in_range;
    reg_sel_e                       w_wr_sel;
    logic [C_AXI_RESP_WIDTH-1:0]    w_bresp;
    logic                           w_do_write;
    logic [C_DATA_WIDTH-1:0]        w_wr_merged;
    logic                           w_done_set;
    logic                           w_timeout_set;
    logic                           w_freeze;
    logic                           w_rd_in_range;
    reg_sel_e                       w_rd_sel;
    logic [C_AXI_DATA_WIDTH-1:0]    w_rd_data;
    logic                           w_unused;

    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    assign S_AXI_AWREADY = r_en && (r_wstate == WR_IDLE || r_wstate == WR_HAVE_W);
    assign S_AXI_WREADY  = r_en && (r_wstate == WR_IDLE || r_wstate == WR_HAVE_AW);
    assign S_AXI_BVALID  = (r_wstate == WR_RESP);
    assign S_AXI_BRESP   = w_bresp;
    assign S_AXI_ARREADY = r_en && (r_rstate == RD_IDLE);
    assign S_AXI_RVALID  = (r_rstate == RD_RESP);
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;

    assign done      = r_done;
    assign exit_code = r_exit_code;
    assign timeout   = r_timeout;

    assign w_aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
    assign w_ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // ---------------- write channel ----------------
    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            WR_IDLE: begin
                if (w_aw_hs && w_w_hs) w_wstate_nxt = WR_RESP;
                else if (w_aw_hs)      w_wstate_nxt = WR_HAVE_AW;
                else if (w_w_hs)       w_wstate_nxt = WR_HAVE_W;
            end
            WR_HAVE_AW: if (w_w_hs)  w_wstate_nxt = WR_RESP;
            WR_HAVE_W:  if (w_aw_hs) w_wstate_nxt = WR_RESP;
            WR_RESP:    if (S_AXI_BREADY) w_wstate_nxt = WR_IDLE;
            default:    w_wstate_nxt = WR_IDLE;
        endcase
    end

    assign w_wr_in_range = in_window(r_awaddr, BASE_ADDR);
    assign w_wr_sel      = reg_of(r_awaddr, BASE_ADDR);

    always_comb begin
        w_bresp = C_RESP_OKAY;
        if (!w_wr_in_range)
            w_bresp = C_RESP_DECERR;
        else if (w_wr_sel != REG_TOHOST && w_wr_sel != REG_LIMIT)
            w_bresp = C_RESP_SLVERR;
    end

    // Register update happens at the end of the first BVALID cycle
    assign w_do_write  = r_wr_first && (w_bresp == C_RESP_OKAY);
    assign w_wr_merged = merge_strb((w_wr_sel == REG_TOHOST) ? r_tohost : r_limit,
                                    r_wdata, r_wstrb);

    assign w_done_set    = w_do_write && (w_wr_sel == REG_TOHOST) &&
                           (w_wr_merged != '0) && !r_done && !r_timeout;
    assign w_timeout_set = (r_limit != '0) && !r_done && !r_timeout &&
                           (r_cycle[31:0] == r_limit) && !w_done_set;
    // Freeze on the detecting edge too so CYCLE_LO stays equal to LIMIT
    assign w_freeze      = r_done || r_timeout || w_timeout_set;

    // ---------------- read channel ----------------
    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            RD_IDLE: if (w_ar_hs)      w_rstate_nxt = RD_RESP;
            RD_RESP: if (S_AXI_RREADY) w_rstate_nxt = RD_IDLE;
            default: w_rstate_nxt = RD_IDLE;
        endcase
    end

    assign w_rd_in_range = in_window(S_AXI_ARADDR, BASE_ADDR);
    assign w_rd_sel      = reg_of(S_AXI_ARADDR, BASE_ADDR);

    always_comb begin
        w_rd_data = '0;
        if (w_rd_in_range) begin
            case (w_rd_sel)
                REG_TOHOST:   w_rd_data = r_tohost;
                REG_STATUS:   w_rd_data = {30'd0, r_timeout, r_done};
                REG_CYCLE_LO: w_rd_data = r_cycle[31:0];
                REG_CYCLE_HI: w_rd_data = r_snap_hi;
                REG_LIMIT:    w_rd_data = r_limit;
                default:      w_rd_data = '0;
            endcase
        end
    end

    // ---------------- sequential ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_en       <= 1'b0;
            r_wstate   <= WR_IDLE;
            r_rstate   <= RD_IDLE;
            r_wr_first <= 1'b0;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_rdata    <= '0;
            r_rresp    <= C_RESP_OKAY;
        end else begin
            r_en       <= 1'b1;
            r_wstate   <= w_wstate_nxt;
            r_rstate   <= w_rstate_nxt;
            r_wr_first <= (w_wstate_nxt == WR_RESP) && (r_wstate != WR_RESP);
            if (w_aw_hs) r_awaddr <= S_AXI_AWADDR;
            if (w_w_hs) begin
                r_wdata <= S_AXI_WDATA;
                r_wstrb <= S_AXI_WSTRB;
            end
            if (w_ar_hs) begin
                r_rdata <= w_rd_data;
                r_rresp <= w_rd_in_range ? C_RESP_OKAY : C_RESP_DECERR;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_tohost    <= '0;
            r_limit     <= '0;
            r_cycle     <= '0;
            r_snap_hi   <= '0;
            r_done      <= 1'b0;
            r_exit_code <= '0;
            r_timeout   <= 1'b0;
        end else begin
            if (w_do_write && w_wr_sel == REG_TOHOST) r_tohost <= w_wr_merged;
            if (w_do_write && w_wr_sel == REG_LIMIT)  r_limit  <= w_wr_merged;
            if (w_done_set) begin
                r_done      <= 1'b1;
                r_exit_code <= w_wr_merged;
            end
            if (w_timeout_set) r_timeout <= 1'b1;
            if (!w_freeze)     r_cycle   <= r_cycle + 64'd1;
            if (w_ar_hs && w_rd_in_range && w_rd_sel == REG_CYCLE_LO)
                r_snap_hi <= r_cycle[63:32];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_tohost.sv
// ============================================================================
//  Module : tb_axi_lite_tohost
//  Brief  : Directed self-checking bench for the AXI4-Lite tohost block.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_axi_lite_tohost;

    localparam logic [31:0] C_BASE = 32'h0001_0000;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_AWADDR = '0;
    logic [2:0]  S_AXI_AWPROT = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_ARADDR = '0;
    logic [2:0]  S_AXI_ARPROT = '0;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        done;
    logic [31:0] exit_code;
    logic        timeout;

    int checks = 0;
    int errors = 0;
    longint unsigned tb_cyc = 0;

    axi_lite_tohost #(.BASE_ADDR(C_BASE)) dut (
        .CLK(CLK), .RST(RST),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_BRESP(S_AXI_BRESP),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .done(done), .exit_code(exit_code), .timeout(timeout)
    );

    always #5 CLK = ~CLK;

    // Expected free-running cycle count: edges seen with reset low
    always @(posedge CLK) tb_cyc <= RST ? 64'd0 : tb_cyc + 64'd1;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge CLK); #1;
        RST = 1'b1;
        repeat (n) @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             input int hold, output logic [1:0] resp, output int bwait);
        bit aw_done = 0;
        bit w_done  = 0;
        bit hs_aw, hs_w;
        int cyc = 0;
        S_AXI_AWADDR = addr;
        S_AXI_WDATA  = data;
        S_AXI_WSTRB  = strb;
        while (!(aw_done && w_done) && cyc < 40) begin
            S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
            S_AXI_WVALID  = !w_done && (cyc >= w_dly);
            @(negedge CLK);
            hs_aw = S_AXI_AWVALID && S_AXI_AWREADY;
            hs_w  = S_AXI_WVALID && S_AXI_WREADY;
            @(posedge CLK); #1;
            if (hs_aw) aw_done = 1;
            if (hs_w)  w_done = 1;
            cyc++;
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        chk("wr_accepted", 64'({aw_done, w_done}), 64'd3);
        bwait = 0;
        while (1) begin
            @(negedge CLK);
            if (S_AXI_BVALID || bwait >= 20) break;
            bwait++;
        end
        chk("bvalid_seen", 64'(S_AXI_BVALID), 64'd1);
        resp = S_AXI_BRESP;
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            chk("b_hold", 64'({S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY}),
                64'({1'b1, resp, 2'b00}));
        end
        S_AXI_BREADY = 1'b1;
        @(posedge CLK); #1;
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input int hold,
                            output logic [31:0] data, output logic [1:0] resp,
                            output longint unsigned cyc_hs);
        bit hs = 0;
        int n = 0;
        cyc_hs = 0;
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        while (!hs && n < 40) begin
            @(negedge CLK);
            hs = S_AXI_ARREADY;
            if (hs) cyc_hs = tb_cyc;
            @(posedge CLK); #1;
            n++;
        end
        S_AXI_ARVALID = 1'b0;
        chk("ar_accepted", 64'(hs), 64'd1);
        n = 0;
        while (1) begin
            @(negedge CLK);
            if (S_AXI_RVALID || n >= 20) break;
            n++;
        end
        chk("rvalid_seen", 64'(S_AXI_RVALID), 64'd1);
        data = S_AXI_RDATA;
        resp = S_AXI_RRESP;
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            chk("r_hold", {S_AXI_RVALID, S_AXI_ARREADY, S_AXI_RRESP, S_AXI_RDATA},
                {1'b1, 1'b0, resp, data});
        end
        S_AXI_RREADY = 1'b1;
        @(posedge CLK); #1;
        S_AXI_RREADY = 1'b0;
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] data;
        logic [31:0] first_lo;
        int          bwait;
        int          n;
        longint unsigned cyc_hs;

        // Reset state and ready release timing
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_outputs", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY,
                                  S_AXI_BVALID, S_AXI_RVALID, done, timeout}), 64'd0);
        chk("reset_exit_code", 64'(exit_code), 64'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("ready_low_at_release", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 64'd0);
        @(negedge CLK);
        chk("ready_high_after_release", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 64'd7);
        @(posedge CLK); #1;

        // LIMIT=100 with W ahead of AW, then timeout
        axi_write(C_BASE + 32'h10, 32'd100, 4'hF, 2, 0, 0, resp, bwait);
        chk("limit_bresp", 64'(resp), 64'd0);
        n = 0;
        while (!timeout && n < 300) begin
            @(negedge CLK);
            n++;
        end
        chk("timeout_set", 64'({timeout, done}), 64'b10);
        @(posedge CLK); #1;
        axi_read(C_BASE + 32'h04, 0, data, resp, cyc_hs);
        chk("status_timeout", 64'({resp, data}), 64'h2);
        axi_read(C_BASE + 32'h08, 0, data, resp, cyc_hs);
        chk("cycle_lo_at_limit", 64'(data), 64'd100);
        repeat (10) @(posedge CLK);
        #1;
        axi_read(C_BASE + 32'h08, 0, data, resp, cyc_hs);
        chk("cycle_lo_frozen", 64'(data), 64'd100);
        axi_read(C_BASE + 32'h0C, 0, data, resp, cyc_hs);
        chk("cycle_hi_snapshot", 64'({resp, data}), 64'd0);
        axi_write(C_BASE, 32'd5, 4'hF, 0, 0, 0, resp, bwait);
        chk("no_done_after_timeout", 64'({resp, done, timeout, exit_code}),
            64'({2'b00, 1'b0, 1'b1, 32'd0}));

        // AW then W two cycles later to TOHOST
        do_reset(1);
        repeat (2) @(posedge CLK);
        #1;
        axi_write(C_BASE, 32'd1, 4'hF, 0, 2, 0, resp, bwait);
        chk("tohost_bresp", 64'(resp), 64'd0);
        chk("bvalid_after_w_latch", 64'(bwait), 64'd0);
        chk("done_exit_code", 64'({done, timeout, exit_code}), 64'({1'b1, 1'b0, 32'd1}));
        axi_read(C_BASE + 32'h04, 0, data, resp, cyc_hs);
        chk("status_done", 64'({resp, data}), 64'h1);
        axi_read(C_BASE + 32'h08, 0, first_lo, resp, cyc_hs);
        repeat (5) @(posedge CLK);
        #1;
        axi_read(C_BASE + 32'h08, 0, data, resp, cyc_hs);
        chk("cycle_frozen_on_done", 64'(data), 64'(first_lo));

        // Read-only write, decode errors, window boundaries
        do_reset(2);
        repeat (2) @(posedge CLK);
        #1;
        axi_write(C_BASE + 32'h08, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, resp, bwait);
        chk("ro_write_slverr", 64'(resp), 64'h2);
        axi_read(C_BASE + 32'h08, 0, data, resp, cyc_hs);
        chk("cycle_lo_counting", 64'({resp, data}), 64'(cyc_hs[31:0]));
        axi_read(C_BASE + 32'h40, 0, data, resp, cyc_hs);
        chk("read_decerr", 64'({resp, data}), 64'({2'b11, 32'd0}));
        axi_write(C_BASE + 32'h40, 32'h1234, 4'hF, 0, 0, 0, resp, bwait);
        chk("write_decerr", 64'({resp, done}), 64'({2'b11, 1'b0}));
        axi_read(C_BASE + 32'h14, 0, data, resp, cyc_hs);
        chk("read_past_window", 64'({resp, data}), 64'({2'b11, 32'd0}));
        axi_read(C_BASE - 32'h4, 0, data, resp, cyc_hs);
        chk("read_below_base", 64'({resp, data}), 64'({2'b11, 32'd0}));
        axi_read(C_BASE + 32'h13, 0, data, resp, cyc_hs);
        chk("read_last_byte_limit", 64'({resp, data}), 64'd0);
        axi_read(C_BASE + 32'h0C, 0, data, resp, cyc_hs);
        chk("cycle_hi_zero", 64'({resp, data}), 64'd0);

        // Byte strobes on TOHOST; exit_code latches only the first time
        axi_write(C_BASE, 32'h0000_AB00, 4'h2, 0, 0, 0, resp, bwait);
        chk("strb_bresp", 64'(resp), 64'd0);
        chk("strb_done", 64'({done, exit_code}), 64'({1'b1, 32'h0000_AB00}));
        axi_read(C_BASE, 0, data, resp, cyc_hs);
        chk("strb_tohost", 64'({resp, data}), 64'h0000_AB00);
        axi_write(C_BASE, 32'h7, 4'hF, 1, 0, 0, resp, bwait);
        axi_read(C_BASE, 0, data, resp, cyc_hs);
        chk("tohost_second", 64'(data), 64'h7);
        chk("exit_code_sticky", 64'(exit_code), 64'h0000_AB00);
        axi_write(C_BASE, 32'hFFFF_FFFF, 4'h4, 0, 0, 0, resp, bwait);
        axi_read(C_BASE, 0, data, resp, cyc_hs);
        chk("strb_byte2", 64'(data), 64'h00FF_0007);

        // Back-pressure on B and R
        axi_write(C_BASE + 32'h10, 32'hDEAD_1234, 4'h3, 0, 0, 5, resp, bwait);
        chk("limit_strb_bresp", 64'(resp), 64'd0);
        axi_read(C_BASE + 32'h10, 5, data, resp, cyc_hs);
        chk("limit_strb_value", 64'({resp, data}), 64'h0000_1234);

        // Reset with AW latched and W pending
        do_reset(1);
        @(posedge CLK); #1;
        S_AXI_AWADDR  = C_BASE;
        S_AXI_AWVALID = 1'b1;
        @(negedge CLK);
        chk("mid_aw_ready", 64'(S_AXI_AWREADY), 64'd1);
        @(posedge CLK); #1;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA   = 32'h55;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_WVALID  = 1'b1;
        RST           = 1'b1;
        @(posedge CLK); #1;
        RST          = 1'b0;
        S_AXI_WVALID = 1'b0;
        @(negedge CLK);
        chk("mid_reset_outputs", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY,
                                      S_AXI_BVALID, S_AXI_RVALID, done, timeout, exit_code}), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("no_bvalid_after_reset", 64'({S_AXI_BVALID, done}), 64'd0);
        end
        @(posedge CLK); #1;
        axi_read(C_BASE + 32'h08, 0, data, resp, cyc_hs);
        chk("counter_restart", 64'(data), 64'(cyc_hs[31:0]));
        chk("counter_small", 64'(data < 32'd20), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
